fetch_predictor: RTL
====================

# fetch_predictor

Fetch-side next-PC unit for the pipelined CPU. It owns the fetch PC register and drives it onto the instruction memory read port. Each cycle it predicts the next PC from a direct-mapped branch target buffer (BTB) and redirects on writeback flushes. Writeback also trains the BTB with the resolved outcome of each conditional jump.

## Interface
Parameters:
- IDX_BITS, 10, BTB index width; the BTB has 2^IDX_BITS entries, indexed by pc[IDX_BITS:1]
- PC_W, 16, PC and target width
- TAG_BITS, PC_W-1-IDX_BITS (5 with defaults), tag width = pc[PC_W-1:IDX_BITS+1]

Ports:
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold fetch PC (pipeline not continuing)
- redirect  in  1  writeback flush; load redirect_pc
- redirect_pc  in  PC_W  correct next PC; bit 0 ignored
- upd_valid  in  1  resolved conditional jump present at writeback
- upd_pc  in  PC_W  PC of resolved jump
- upd_taken  in  1  jump resolved taken
- upd_target  in  PC_W  resolved target; bit 0 ignored
- pc  out  PC_W  current fetch address; bit 0 always 0
- fetch_valid  out  1  pc holds a real fetch address
- pred_taken  out  1  BTB predicts taken for current pc (combinational)
- pred_next  out  PC_W  predicted next PC for current pc (combinational)

## Operation
- Each BTB entry holds: valid (reset to 0), tag, target, and a 2-bit counter (only with BTB_HYST_EN). Tag, target and counter have no reset.
- Lookup is on the current pc.
  - hit = valid & tag == pc[PC_W-1:IDX_BITS+1].
  - pred_taken = hit & counter >= 2.
  - pred_next = pred_taken ? target : pc + 2. The add is modulo 2^PC_W, so 0xFFFE wraps to 0x0000.
- PC update on each clk edge, in priority order:
  - redirect: pc <= {redirect_pc[PC_W-1:1], 0}.
  - else stall: pc holds.
  - else: pc <= pred_next.
  - Redirect overrides stall.
- Training on upd_valid; it applies regardless of stall or redirect.
  - Taken, hit: counter saturating-increments (max 3); target <= upd_target.
  - Taken, miss: allocate the entry. valid <= 1, tag and target written, counter <= 2.
  - Not taken, hit: counter saturating-decrements (min 0); the entry stays valid.
  - Not taken, miss: no change.
- fetch_valid is 0 from reset. It is set to 1 on the first clk edge after rst_n deasserts and stays 1.

## Timing
- Reset values: pc = 0x0000, fetch_valid = 0, all valid bits = 0. Consequently pred_taken = 0 and pred_next = 0x0002.
- redirect to pc: 1 cycle; pc equals redirect_pc in the cycle after redirect is sampled.
- Update to lookup: 1 cycle. When a lookup and an update hit the same index in the same cycle, the lookup sees the old contents.
- rst_n asserted mid-operation: pc, fetch_valid and valid bits clear immediately, without waiting for clk. An update in flight at that point is discarded.
- Prediction outputs are combinational from the pc register and BTB state; there is no path from the inputs to them.

## Configuration
- BTB_HYST_EN defined: behaviour as above, with 2-bit hysteresis counters.
- BTB_HYST_EN undefined: no counters are stored.
  - pred_taken = hit.
  - Taken update writes valid, tag and target.
  - Not-taken update that hits clears valid.

## Test plan
- Reset, then no stimulus for 4 cycles -> pc sequence 0x0000, 0x0002, 0x0004, 0x0006; fetch_valid is 0 only during reset.
- upd_valid with upd_pc=0x0010, taken, target 0x0100; then redirect to 0x0010 -> pred_taken=1, and the next pc is 0x0100.
- BTB_HYST_EN: train 0x0010 taken twice (counter 3), then not-taken once -> still predicts 0x0100; a second not-taken -> predicts 0x0012. Without the macro, the first not-taken already gives 0x0012.
- Alias: train 0x0010 taken, then fetch 0x0810 (same index, different tag) -> pred_taken=0, next pc 0x0812.
- stall held 3 cycles at pc=0x0020 -> pc stays 0x0020. Redirect to 0x0040 during the stall -> pc becomes 0x0040 the next cycle.
- pc=0xFFFE with no BTB hit -> next pc is 0x0000. Assert rst_n low mid-cycle -> pc is 0x0000 before the next clk edge.

Source files
------------

// File: rtl/fetch_predictor.sv
// -----------------------------------------------------------------------------
// fetch_predictor
//
// Fetch-side next-PC unit. Owns the fetch PC register and predicts the next PC
// each cycle from a direct-mapped branch target buffer (BTB). A writeback
// redirect overrides everything; stall holds the PC. Writeback also trains the
// BTB with the resolved outcome of each conditional jump.
//
// Configuration macro: BTB_HYST_EN
//   defined   : each entry carries a 2-bit saturating counter, taken when >= 2
//   undefined : no counters; a valid tag hit predicts taken, a not-taken hit
//               invalidates the entry
//
// Ports:
//   clk          in   1     clock, all state on rising edge
//   rst_n        in   1     asynchronous active-low reset
//   stall        in   1     hold fetch PC
//   redirect     in   1     writeback flush; load redirect_pc
//   redirect_pc  in   PC_W  correct next PC (bit 0 ignored)
//   upd_valid    in   1     resolved conditional jump at writeback
//   upd_pc       in   PC_W  PC of the resolved jump
//   upd_taken    in   1     jump resolved taken
//   upd_target   in   PC_W  resolved target (bit 0 ignored)
//   pc           out  PC_W  current fetch address (bit 0 always 0)
//   fetch_valid  out  1     pc holds a real fetch address
//   pred_taken   out  1     BTB predicts taken for pc (combinational)
//   pred_next    out  PC_W  predicted next PC for pc (combinational)
// -----------------------------------------------------------------------------
module fetch_predictor #(
  parameter int IDX_BITS = 10,
  parameter int PC_W     = 16,
  parameter int TAG_BITS = PC_W - 1 - IDX_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_next
);

  localparam int DEPTH = 1 << IDX_BITS;

  // Sequential fetch step and the mask that forces halfword alignment.
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);
  localparam logic [PC_W-1:0] PC_MASK = ~(PC_W'(1));

`ifdef BTB_HYST_EN
  // Saturating counter helpers (max 3, min 0).
  function automatic logic [1:0] ctr_sat_inc(input logic [1:0] ctr);
    logic [1:0] res;
    if (ctr == 2'd3) begin
      res = 2'd3;
    end else begin
      res = ctr + 2'd1;
    end
    return res;
  endfunction

  function automatic logic [1:0] ctr_sat_dec(input logic [1:0] ctr);
    logic [1:0] res;
    if (ctr == 2'd0) begin
      res = 2'd0;
    end else begin
      res = ctr - 2'd1;
    end
    return res;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PC_W-1:0]     pc_r;
  logic                fetch_valid_r;
  logic [DEPTH-1:0]    valid_r;
  logic [TAG_BITS-1:0] tag_mem_r [DEPTH];
  logic [PC_W-1:0]     tgt_mem_r [DEPTH];
`ifdef BTB_HYST_EN
  logic [1:0]          ctr_mem_r [DEPTH];
`endif

  // ---------------------------------------------------------------------------
  // Lookup on the current pc
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] look_idx_s;
  logic [TAG_BITS-1:0] look_tag_s;
  logic                look_hit_s;
  logic                pred_taken_s;
  logic [PC_W-1:0]     pred_next_s;
  logic [PC_W-1:0]     pc_next_s;

  assign look_idx_s = pc_r[IDX_BITS:1];
  assign look_tag_s = pc_r[PC_W-1:IDX_BITS+1];
  assign look_hit_s = valid_r[look_idx_s] && (tag_mem_r[look_idx_s] == look_tag_s);

  // Prediction is a pure function of pc_r and BTB state.
  always_comb begin
    pred_taken_s = 1'b0;
    pred_next_s  = pc_r + PC_STEP;
`ifdef BTB_HYST_EN
    if (look_hit_s && (ctr_mem_r[look_idx_s] >= 2'd2)) begin
      pred_taken_s = 1'b1;
    end else begin
      pred_taken_s = 1'b0;
    end
`else
    if (look_hit_s) begin
      pred_taken_s = 1'b1;
    end else begin
      pred_taken_s = 1'b0;
    end
`endif
    if (pred_taken_s) begin
      pred_next_s = tgt_mem_r[look_idx_s];
    end else begin
      pred_next_s = pc_r + PC_STEP;
    end
  end

  // Next fetch PC selection: redirect beats stall beats prediction.
  always_comb begin
    pc_next_s = pred_next_s;
    if (redirect) begin
      pc_next_s = redirect_pc & PC_MASK;
    end else if (stall) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pred_next_s;
    end
  end

  // Fetch PC and fetch_valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= '0;
      fetch_valid_r <= 1'b0;
    end else begin
      pc_r          <= pc_next_s;
      fetch_valid_r <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Training from writeback
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] upd_idx_s;
  logic [TAG_BITS-1:0] upd_tag_s;
  logic                upd_hit_s;
  logic                valid_set_s;
  logic                valid_clr_s;
  logic                tag_we_s;
  logic                tgt_we_s;
`ifdef BTB_HYST_EN
  logic                ctr_we_s;
  logic [1:0]          ctr_next_s;
`endif

  assign upd_idx_s = upd_pc[IDX_BITS:1];
  assign upd_tag_s = upd_pc[PC_W-1:IDX_BITS+1];
  assign upd_hit_s = valid_r[upd_idx_s] && (tag_mem_r[upd_idx_s] == upd_tag_s);

  // Decode the training action for this cycle's resolved jump.
  always_comb begin
    valid_set_s = 1'b0;
    valid_clr_s = 1'b0;
    tag_we_s    = 1'b0;
    tgt_we_s    = 1'b0;
`ifdef BTB_HYST_EN
    ctr_we_s    = 1'b0;
    ctr_next_s  = 2'd0;
    if (upd_valid && upd_taken) begin
      tgt_we_s = 1'b1;
      ctr_we_s = 1'b1;
      if (upd_hit_s) begin
        ctr_next_s = ctr_sat_inc(ctr_mem_r[upd_idx_s]);
      end else begin
        // Allocate a fresh entry, starting weakly taken.
        valid_set_s = 1'b1;
        tag_we_s    = 1'b1;
        ctr_next_s  = 2'd2;
      end
    end else if (upd_valid && upd_hit_s) begin
      // Not taken but hit: weaken, entry stays valid.
      ctr_we_s   = 1'b1;
      ctr_next_s = ctr_sat_dec(ctr_mem_r[upd_idx_s]);
    end else begin
      ctr_we_s = 1'b0;
    end
`else
    if (upd_valid && upd_taken) begin
      valid_set_s = 1'b1;
      tag_we_s    = 1'b1;
      tgt_we_s    = 1'b1;
    end else if (upd_valid && upd_hit_s) begin
      valid_clr_s = 1'b1;
    end else begin
      valid_set_s = 1'b0;
    end
`endif
  end

  // Valid bits: the only BTB state under reset, so an update racing an
  // asynchronous reset is discarded here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (valid_set_s) begin
      valid_r[upd_idx_s] <= 1'b1;
    end else if (valid_clr_s) begin
      valid_r[upd_idx_s] <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag, target and counter arrays are unreset; writes during reset are
  // harmless because the entry is invalid until a later allocation rewrites
  // every field.
  always_ff @(posedge clk) begin
    if (tag_we_s) begin
      tag_mem_r[upd_idx_s] <= upd_tag_s;
    end
    if (tgt_we_s) begin
      tgt_mem_r[upd_idx_s] <= upd_target & PC_MASK;
    end
`ifdef BTB_HYST_EN
    if (ctr_we_s) begin
      ctr_mem_r[upd_idx_s] <= ctr_next_s;
    end
`endif
  end

  // Bit 0 of upd_pc carries no information for indexing or tagging.
  logic unused_bits_s;
  assign unused_bits_s = upd_pc[0];

  assign pc          = pc_r;
  assign fetch_valid = fetch_valid_r;
  assign pred_taken  = pred_taken_s;
  assign pred_next   = pred_next_s;

endmodule
